// File: rtl/systolic_operand_loader_pkg.sv
// Shared definitions for the systolic operand loader: state encoding, operand
// counts and the mapping from stream slot to image/filter position.
package systolic_operand_loader_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned IMG_BYTES   = 16;
    localparam int unsigned FILT_BYTES  = 9;
    localparam int unsigned TOTAL_BYTES = IMG_BYTES + FILT_BYTES;
    localparam int unsigned IDX_W       = 5;

    // Stream slots 0..15 are image bytes, 16..24 are filter bytes.
    function automatic bit slot_is_img(int unsigned slot);
        return slot < IMG_BYTES;
    endfunction

    function automatic int unsigned slot_pos(int unsigned slot);
        return slot_is_img(slot) ? slot : slot - IMG_BYTES;
    endfunction

endpackage

// File: rtl/systolic_operand_loader_if.sv
// Valid/ready byte stream feeding the operand loader.
interface systolic_operand_loader_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/systolic_operand_loader_operand_bank.sv
// 25-entry operand register file; each slot is wired straight to its position
// on the flattened image or filter output bus.
module operand_bank
    import systolic_operand_loader_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                         clk_in,
    input  logic                         rst,
    input  logic                         we,
    input  logic [IDX_W-1:0]             widx,
    input  logic [DATA_W-1:0]            wdata,
    output logic [IMG_BYTES*DATA_W-1:0]  img_flat,
    output logic [FILT_BYTES*DATA_W-1:0] filt_flat
);

    for (genvar g = 0; g < TOTAL_BYTES; g++) begin : g_slot
        logic [DATA_W-1:0] q;

        always_ff @(posedge clk_in) begin
            if (rst) begin
                q <= '0;
            end else if (we && (widx == IDX_W'(g))) begin
                q <= wdata;
            end
        end

        if (slot_is_img(g)) begin : g_img
            assign img_flat[slot_pos(g)*DATA_W +: DATA_W] = q;
        end else begin : g_filt
            assign filt_flat[slot_pos(g)*DATA_W +: DATA_W] = q;
        end
    end

endmodule

// File: rtl/systolic_operand_loader.sv
// Loads 16 image + 9 filter bytes, then releases the systolic array's reset for
// RUN_CYCLES cycles and holds done until the controller acknowledges.
module systolic_operand_loader
    import systolic_operand_loader_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int RUN_CYCLES = 20
) (
    input  logic                         clk_in,
    input  logic                         rst,
    systolic_operand_loader_if.slave     s,
    output logic [IMG_BYTES*DATA_W-1:0]  img_flat,
    output logic [FILT_BYTES*DATA_W-1:0] filt_flat,
    output logic                         array_rst,
    output logic                         done,
    input  logic                         ack
);

    localparam logic [7:0]       RUN_LAST = 8'(RUN_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_BYTES - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [7:0]       run_cnt;
    logic             xfer;

    assign s.s_ready = (state == LOAD);
    assign xfer      = s.s_valid && (state == LOAD);

    // array_rst/done are set alongside the state transition so they track the
    // next state without a decode stage.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= LOAD;
            idx       <= '0;
            run_cnt   <= '0;
            array_rst <= 1'b1;
            done      <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (xfer) begin
                        if (idx == LAST_IDX) begin
                            idx       <= '0;
                            run_cnt   <= '0;
                            state     <= RUN;
                            array_rst <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                RUN: begin
                    run_cnt <= run_cnt + 1'b1;
                    if (run_cnt == RUN_LAST) begin
                        state     <= DONE;
                        array_rst <= 1'b1;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    if (ack) begin
                        state <= LOAD;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state     <= LOAD;
                    array_rst <= 1'b1;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    operand_bank #(
        .DATA_W(DATA_W)
    ) u_bank (
        .clk_in   (clk_in),
        .rst      (rst),
        .we       (xfer),
        .widx     (idx),
        .wdata    (s.s_data),
        .img_flat (img_flat),
        .filt_flat(filt_flat)
    );

endmodule

// File: doc/systolic_operand_loader.md
# systolic_operand_loader

Upstream feeder for the 3x3-filter / 4x4-input systolic convolution array. It receives a byte stream over a valid/ready handshake: 16 image bytes, then 9 filter bytes. It holds all 25 operands on parallel registered outputs. It then releases the array's reset for a fixed compute window and signals completion to the controller. This keeps operands stable for the whole array run and gives the array a clean restart for every frame.

## Interface
- `DATA_W`, 8, operand byte width
- `RUN_CYCLES`, 20, cycles `array_rst` stays low per frame. Must cover the array's 15-count sequencing plus 3 cycles of output settling; legal range 1..255.
- `clk_in`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  reset; one clock, synchronous, active-high
- `s_data`  in  DATA_W  stream byte
- `s_valid`  in  1  `s_data` valid
- `s_ready`  out  1  loader accepts a byte this cycle
- `img_flat`  out  16*DATA_W  image operands, row-major: byte k at bits [8k+7:8k]; k=0 is i00, k=15 is i33
- `filt_flat`  out  9*DATA_W  filter operands, row-major: k=0 is f00, k=8 is f22
- `array_rst`  out  1  reset for the systolic array; high except in RUN
- `done`  out  1  frame computed; array outputs are valid
- `ack`  in  1  controller consumed results; returns loader to LOAD

## Operation
- States: LOAD, RUN, DONE. The state register and 5-bit byte index `idx` (0..24) are registered.
- Handshake:
  - A transfer occurs on a clock edge with `s_valid` && `s_ready`.
  - `s_ready` = (state==LOAD), combinational from state only, never from `s_valid`.
- LOAD behaviour:
  - Each transfer writes `s_data` into operand slot `idx`. Slots 0..15 go to image positions 0..15; slots 16..24 go to filter positions 0..8.
  - `idx` increments on each transfer.
  - The transfer at `idx`==24 sets `idx` to 0 and moves to RUN.
  - `s_valid` low: nothing changes, and the stream may stall arbitrarily.
- RUN behaviour:
  - An 8-bit `run_cnt` loads 0 on entry and increments each cycle.
  - When `run_cnt`==RUN_CYCLES-1, the next state is DONE.
  - `s_data`/`s_valid` are ignored.
- DONE behaviour:
  - `done`=1.
  - `ack`=1 causes the next state LOAD, with `done` low the following cycle.
  - `ack` in LOAD or RUN is ignored.
- Operand registers change only on LOAD transfers. A new frame overwrites slots progressively, so outputs are unspecified as a whole until the 25th byte. The downstream array is held in reset throughout.
- `array_rst` and `done` are registered (decoded into flops from next state), so they carry no glitches.
- Reset values:
  - state=LOAD, `idx`=0, `run_cnt`=0
  - all operand bytes 0
  - `array_rst`=1, `done`=0
  - `s_ready`=1 in the first cycle after `rst` falls
- Reset mid-operation (any state) aborts the frame and reaches the reset values on the next edge. Partially loaded bytes are discarded by clearing to 0.
- `rst` has priority over every transfer and `ack` in the same cycle.

## Timing
- Throughput: one byte per cycle; minimum load time 25 cycles.
- The 25th transfer at edge T gives, from edge T onward:
  - state=RUN, `array_rst`=0, `s_ready`=0
  - the filter byte is visible on `filt_flat` at the same edge
- `array_rst` stays 0 for exactly RUN_CYCLES cycles: it rises at edge T+RUN_CYCLES, together with `done`=1.
- `ack` high at edge D, with `done` high, gives `done`=0 and `s_ready`=1 after D.
- Back-to-back frames: the earliest next transfer is the edge after `ack` is sampled.
- Frame latency (zero stall, `ack` tied high): 25 + RUN_CYCLES + 1 cycles, byte 0 to the first byte of the next frame.

## Structure
- A shared package holds:
  - the state encoding (LOAD=2'd0, RUN=2'd1, DONE=2'd2)
  - the constants IMG_BYTES=16, FILT_BYTES=9, TOTAL_BYTES=25
  - the flattened-slot index helpers
- One sub-module, `operand_bank`: 25 x DATA_W register file with write enable and 5-bit write index, synchronous clear on `rst`, and flattened read outputs. The FSM, counters and handshake stay in the top.

## Test plan
- **Reset values:** reset then idle, checked at every cycle through cycle 10 -> `s_ready`=1, `array_rst`=1, `done`=0, `img_flat`=0, `filt_flat`=0.
- **Full frame, no stalls:** bytes 1..25 on consecutive cycles -> i00=1, i33=16, f00=17, f22=25. `array_rst` low exactly 20 cycles, then `done`=1, held until `ack`.
- **Stalled stream:** `s_valid` toggling 1,0,0,1 pattern -> the same operand mapping as the no-stall frame, `s_ready` never drops in LOAD, and only sampled bytes are stored.
- **Bytes outside LOAD:** `s_valid`=1 with data 0xFF throughout RUN and DONE -> operands unchanged; `ack` during RUN ignored.
- **Reset mid-load:** `rst` after 12 bytes -> all operands 0 and `idx` restarts. A following 25-byte frame maps correctly.
- **Back-to-back with RUN_CYCLES=3:** `ack` held high -> a 3-cycle `array_rst` low window per frame, and the second frame's first byte accepted on the cycle after DONE.
